mem_stage_ctrl: RTL and testbench

- Memory-stage controller on the consumer side of the EX/MEM pipeline register in the pipelined processor.
- Takes the EX/MEM outputs and runs the data-memory request/acknowledge handshake, stalling upstream stages while an access is outstanding.
- Resolves branches and jumps (PC select, target, flush).
- Registers results into the MEM/WB stage. Its stall output drives the EX/MEM enable (enable = ~oStall).

---
 rtl/mem_stage_ctrl_if.sv | 28 ++
 rtl/mem_stage_ctrl.sv | 142 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus between the MEM-stage controller and the data memory.
// The controller drives the request side; the memory answers with ack/read data.
interface mem_stage_ctrl_if;
    logic        oMemReq;
    logic        oMemWe;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic [31:0] iMemRData;
    logic        iMemAck;

    modport master (
        output oMemReq,
        output oMemWe,
        output oMemAddr,
        output oMemWData,
        input  iMemRData,
        input  iMemAck
    );

    modport slave (
        input  oMemReq,
        input  oMemWe,
        input  oMemAddr,
        input  oMemWData,
        output iMemRData,
        output iMemAck
    );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: sits behind the EX/MEM register, runs the data-memory
// request/ack handshake, stalls the front of the pipe while an access is
// outstanding, resolves branches/jumps and fills the MEM/WB register.
module mem_stage_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iRegWrite,
    input  logic                   iMemRead,
    input  logic                   iMemWrite,
    input  logic                   iMemToReg,
    input  logic                   iBranchs,
    input  logic                   iJumps,
    input  logic [31:0]            iPC,
    input  logic [31:0]            iResult,
    input  logic [31:0]            iB,
    input  logic [31:0]            iBranch,
    input  logic [31:0]            iJump,
    input  logic                   iZero,
    input  logic [4:0]             iRegDest,
    mem_stage_ctrl_if.master       mem,
    output logic                   oStall,
    output logic                   oPCSrc,
    output logic [31:0]            oPCTarget,
    output logic                   oFlush,
    output logic                   oWbRegWrite,
    output logic                   oWbMemToReg,
    output logic [31:0]            oWbReadData,
    output logic [31:0]            oWbResult,
    output logic [4:0]             oWbRegDest,
    output logic [31:0]            oWbPC,
    output logic                   oMemErr
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    // The counter holds how many request cycles the access has already used,
    // so the first WAIT cycle sees 1 (the IDLE request cycle counts too).
    localparam bit               TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 1) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t           state;
    state_t           stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;

    logic memOp;
    logic timeout;
    logic done;
    logic redirect;

    assign memOp   = iMemRead | iMemWrite;
    assign timeout = (state == WAIT) && TIMEOUT_EN && (cnt >= TIMEOUT_LAST);
    assign done    = mem.iMemAck | timeout;

    assign mem.oMemReq   = memOp & ~reset;
    assign mem.oMemWe    = iMemWrite & mem.oMemReq;
    assign mem.oMemAddr  = iResult;
    assign mem.oMemWData = iB;

    assign oStall    = memOp & ~done & ~reset;
    assign redirect  = ((iBranchs & iZero) | iJumps) & ~oStall & ~reset;
    assign oPCSrc    = redirect;
    assign oFlush    = redirect;
    assign oPCTarget = iJumps ? iJump : iBranch;

    // FSM state and wait-counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state: leave IDLE only when the memory did not answer at once
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        case (state)
            IDLE: begin
                if (memOp && !mem.iMemAck) begin
                    stateNext = WAIT;
                    cntNext   = CNT_W'(1);
                end else begin
                    cntNext   = '0;
                end
            end
            WAIT: begin
                if (done) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else begin
                    cntNext   = cnt + CNT_W'(1);
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = '0;
            end
        endcase
    end

    // MEM/WB register: bubbles while stalled, real entry once the access is done
    always_ff @(posedge clock) begin
        if (reset) begin
            oWbRegWrite <= 1'b0;
            oWbMemToReg <= 1'b0;
            oWbReadData <= '0;
            oWbResult   <= '0;
            oWbRegDest  <= '0;
            oWbPC       <= '0;
            oMemErr     <= 1'b0;
        end else begin
            if (oStall) begin
                oWbRegWrite <= 1'b0;
                oWbMemToReg <= 1'b0;
                oMemErr     <= 1'b0;
            end else begin
                oWbRegWrite <= iRegWrite;
                oWbMemToReg <= iMemToReg;
                oWbResult   <= iResult;
                oWbRegDest  <= iRegDest;
                oWbPC       <= iPC;
                oMemErr     <= timeout & ~mem.iMemAck;
            end
            if (iMemRead && mem.iMemAck) begin
                oWbReadData <= mem.iMemRData;
            end else if (iMemRead && timeout) begin
                oWbReadData <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized transactions against a transaction model.
module tb_mem_stage_ctrl;

    localparam int T = 4;

    typedef struct {
        logic        regWrite, memRead, memWrite, memToReg, branchs, jumps, zero;
        logic [31:0] pc, result, b, branch, jump, rdata;
        logic [4:0]  regDest;
        int          delay;
    } op_t;

    typedef struct {
        op_t         op;
        logic        ack;
        logic        expReq, expWe, expPCSrc;
        logic [31:0] expTarget, expReadData;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        iRegWrite, iMemRead, iMemWrite, iMemToReg, iBranchs, iJumps, iZero;
    logic [31:0] iPC, iResult, iB, iBranch, iJump;
    logic [4:0]  iRegDest;
    logic        oStall, oPCSrc, oFlush, oWbRegWrite, oWbMemToReg, oMemErr;
    logic [31:0] oPCTarget, oWbReadData, oWbResult, oWbPC;
    logic [4:0]  oWbRegDest;

    int checks   = 0;
    int failures = 0;

    logic [31:0] expReadData, expResult, expPC;
    logic [4:0]  expRegDest;

    vec_t vecs [9];

    mem_stage_ctrl_if memBus ();

    mem_stage_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .iRegWrite   (iRegWrite),
        .iMemRead    (iMemRead),
        .iMemWrite   (iMemWrite),
        .iMemToReg   (iMemToReg),
        .iBranchs    (iBranchs),
        .iJumps      (iJumps),
        .iPC         (iPC),
        .iResult     (iResult),
        .iB          (iB),
        .iBranch     (iBranch),
        .iJump       (iJump),
        .iZero       (iZero),
        .iRegDest    (iRegDest),
        .mem         (memBus),
        .oStall      (oStall),
        .oPCSrc      (oPCSrc),
        .oPCTarget   (oPCTarget),
        .oFlush      (oFlush),
        .oWbRegWrite (oWbRegWrite),
        .oWbMemToReg (oWbMemToReg),
        .oWbReadData (oWbReadData),
        .oWbResult   (oWbResult),
        .oWbRegDest  (oWbRegDest),
        .oWbPC       (oWbPC),
        .oMemErr     (oMemErr)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic op_t mkOp(input logic rw, rd, wr, m2r, br, j, z,
                                 input logic [31:0] pc, result, b, branch, jump, rdata,
                                 input logic [4:0] regDest, input int delay);
        op_t o;
        o.regWrite = rw;  o.memRead = rd; o.memWrite = wr; o.memToReg = m2r;
        o.branchs  = br;  o.jumps   = j;  o.zero     = z;
        o.pc = pc; o.result = result; o.b = b; o.branch = branch; o.jump = jump;
        o.rdata = rdata; o.regDest = regDest; o.delay = delay;
        return o;
    endfunction

    function automatic vec_t mkVec(input op_t op, input logic ack, req, we, pcSrc,
                                   input logic [31:0] target, readData);
        vec_t v;
        v.op = op; v.ack = ack; v.expReq = req; v.expWe = we; v.expPCSrc = pcSrc;
        v.expTarget = target; v.expReadData = readData;
        return v;
    endfunction

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input op_t op, input logic ack, input logic [31:0] rdata);
        iRegWrite = op.regWrite; iMemRead = op.memRead; iMemWrite = op.memWrite;
        iMemToReg = op.memToReg; iBranchs = op.branchs; iJumps = op.jumps; iZero = op.zero;
        iPC = op.pc; iResult = op.result; iB = op.b; iBranch = op.branch; iJump = op.jump;
        iRegDest = op.regDest;
        memBus.iMemAck   = ack;
        memBus.iMemRData = rdata;
    endtask

    task automatic stepClock();
        @(posedge clock);
        #1;
    endtask

    task automatic checkComb(input string tag, input logic req, we, stall, pcSrc,
                             input logic [31:0] addr, wdata, target);
        checkBit({tag, " memReq"}, memBus.oMemReq, req);
        checkBit({tag, " memWe"}, memBus.oMemWe, we);
        checkOutput({tag, " memAddr"}, memBus.oMemAddr, addr);
        checkOutput({tag, " memWData"}, memBus.oMemWData, wdata);
        checkBit({tag, " stall"}, oStall, stall);
        checkBit({tag, " pcSrc"}, oPCSrc, pcSrc);
        checkBit({tag, " flush"}, oFlush, pcSrc);
        checkOutput({tag, " pcTarget"}, oPCTarget, target);
    endtask

    task automatic checkWb(input string tag, input logic regWrite, memToReg, err,
                           input logic [31:0] readData, result, pc, input logic [4:0] regDest);
        checkBit({tag, " wbRegWrite"}, oWbRegWrite, regWrite);
        checkBit({tag, " wbMemToReg"}, oWbMemToReg, memToReg);
        checkBit({tag, " memErr"}, oMemErr, err);
        checkOutput({tag, " wbReadData"}, oWbReadData, readData);
        checkOutput({tag, " wbResult"}, oWbResult, result);
        checkOutput({tag, " wbPC"}, oWbPC, pc);
        checkOutput({tag, " wbRegDest"}, 32'(oWbRegDest), 32'(regDest));
    endtask

    // Transaction-level model: an access acked after `delay` extra cycles is
    // forced to finish on request cycle T-1; every earlier cycle is a stall.
    task automatic runOp(input string tag, input op_t op);
        logic        memOp, taken, timedOut, ack, expStall;
        logic [31:0] rdata;
        int          doneIdx;
        memOp    = op.memRead | op.memWrite;
        taken    = (op.branchs & op.zero) | op.jumps;
        doneIdx  = !memOp ? 0 : ((op.delay < T - 1) ? op.delay : T - 1);
        timedOut = memOp && (op.delay > T - 1);
        for (int k = 0; k <= doneIdx; k++) begin
            ack      = memOp ? (k == op.delay) : (op.delay % 2 == 1);
            rdata    = ack ? op.rdata : $urandom();
            expStall = memOp && (k < doneIdx);
            applyStimulus(op, ack, rdata);
            #1;
            checkComb($sformatf("%s c%0d", tag, k), memOp, op.memWrite, expStall,
                      taken && !expStall, op.result, op.b, op.jumps ? op.jump : op.branch);
            stepClock();
            if (expStall) begin
                checkWb($sformatf("%s bubble%0d", tag, k), 1'b0, 1'b0, 1'b0,
                        expReadData, expResult, expPC, expRegDest);
            end else begin
                expResult  = op.result;
                expPC      = op.pc;
                expRegDest = op.regDest;
                if (op.memRead && ack)           expReadData = op.rdata;
                else if (op.memRead && timedOut) expReadData = 32'h0;
                checkWb($sformatf("%s wb", tag), op.regWrite, op.memToReg, timedOut,
                        expReadData, expResult, expPC, expRegDest);
            end
        end
    endtask

    function automatic op_t randomOp();
        int          kind;
        logic [31:0] pc, res, b, br, jp, rd;
        logic [4:0]  dst;
        kind = $urandom_range(0, 4);
        pc = $urandom(); res = $urandom(); b = $urandom(); br = $urandom();
        jp = $urandom(); rd = $urandom(); dst = 5'($urandom_range(0, 31));
        case (kind)
            0: return mkOp(1'($urandom_range(0, 1)), 0, 0, 0, 0, 0, 1'($urandom_range(0, 1)),
                           pc, res, b, br, jp, rd, dst, $urandom_range(0, 3));
            1: return mkOp(0, 0, 0, 0, 1, 0, 1'($urandom_range(0, 1)),
                           pc, res, b, br, jp, rd, dst, $urandom_range(0, 3));
            2: return mkOp(0, 0, 0, 0, 0, 1, 1'($urandom_range(0, 1)),
                           pc, res, b, br, jp, rd, dst, $urandom_range(0, 3));
            3: return mkOp(1, 1, 0, 1, 0, 0, 0, pc, res, b, br, jp, rd, dst, $urandom_range(0, 6));
            default: return mkOp(0, 0, 1, 0, 0, 0, 0, pc, res, b, br, jp, rd, dst, $urandom_range(0, 6));
        endcase
    endfunction

    // Main test sequence
    initial begin
        op_t op;

        vecs[0] = mkVec(mkOp(1,0,0,0,0,0,0, 32'h1000, 32'h11, 32'h22, 32'h500, 32'h600, 32'h0, 5'd3, 0),
                        0, 0, 0, 0, 32'h500, 32'h0);
        vecs[1] = mkVec(mkOp(1,1,0,1,0,0,0, 32'h1004, 32'h100, 32'h0, 32'h500, 32'h600, 32'hDEADBEEF, 5'd5, 0),
                        1, 1, 0, 0, 32'h500, 32'hDEADBEEF);
        vecs[2] = mkVec(mkOp(0,0,0,0,1,0,1, 32'h1008, 32'h0, 32'h0, 32'h200, 32'h600, 32'h0, 5'd0, 0),
                        0, 0, 0, 1, 32'h200, 32'hDEADBEEF);
        vecs[3] = mkVec(mkOp(0,0,0,0,1,0,0, 32'h100C, 32'h0, 32'h0, 32'h200, 32'h600, 32'h0, 5'd0, 0),
                        0, 0, 0, 0, 32'h200, 32'hDEADBEEF);
        vecs[4] = mkVec(mkOp(0,0,0,0,0,1,0, 32'h1010, 32'h0, 32'h0, 32'h200, 32'h3000, 32'h0, 5'd0, 0),
                        0, 0, 0, 1, 32'h3000, 32'hDEADBEEF);
        vecs[5] = mkVec(mkOp(0,0,1,0,0,0,0, 32'h1014, 32'h40, 32'h12345678, 32'h500, 32'h600, 32'hFFFF0000, 5'd2, 0),
                        1, 1, 1, 0, 32'h500, 32'hDEADBEEF);
        vecs[6] = mkVec(mkOp(1,0,0,0,0,0,0, 32'h1018, 32'h77, 32'h0, 32'h500, 32'h600, 32'hAAAA5555, 5'd4, 0),
                        1, 0, 0, 0, 32'h500, 32'hDEADBEEF);
        vecs[7] = mkVec(mkOp(1,1,0,1,0,0,0, 32'h101C, 32'h104, 32'h0, 32'h500, 32'h600, 32'hCAFEF00D, 5'd9, 0),
                        1, 1, 0, 0, 32'h500, 32'hCAFEF00D);
        vecs[8] = mkVec(mkOp(0,0,0,0,1,1,1, 32'h1020, 32'h0, 32'h0, 32'h200, 32'h3000, 32'h0, 5'd0, 0),
                        0, 0, 0, 1, 32'h3000, 32'hCAFEF00D);

        // Reset: request, stall and redirect forced low; MEM/WB cleared
        reset = 1'b1;
        applyStimulus(mkOp(1,1,0,1,0,1,0, 32'h10, 32'h100, 32'h0, 32'h200, 32'h300, 32'h0, 5'd7, 0),
                      1'b0, 32'h0);
        #1;
        checkBit("reset memReq", memBus.oMemReq, 1'b0);
        checkBit("reset stall", oStall, 1'b0);
        checkBit("reset pcSrc", oPCSrc, 1'b0);
        checkBit("reset flush", oFlush, 1'b0);
        stepClock();
        stepClock();
        checkWb("reset", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        reset = 1'b0;
        expReadData = '0; expResult = '0; expPC = '0; expRegDest = '0;

        // Directed single-cycle vectors
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].op, vecs[i].ack, vecs[i].op.rdata);
            #1;
            checkComb($sformatf("vec%0d", i), vecs[i].expReq, vecs[i].expWe, 1'b0,
                      vecs[i].expPCSrc, vecs[i].op.result, vecs[i].op.b, vecs[i].expTarget);
            stepClock();
            checkWb($sformatf("vec%0d", i), vecs[i].op.regWrite, vecs[i].op.memToReg, 1'b0,
                    vecs[i].expReadData, vecs[i].op.result, vecs[i].op.pc, vecs[i].op.regDest);
            expReadData = vecs[i].expReadData;
            expResult   = vecs[i].op.result;
            expPC       = vecs[i].op.pc;
            expRegDest  = vecs[i].op.regDest;
        end

        // Multi-cycle corner cases
        runOp("load3wait", mkOp(1,1,0,1,0,0,0, 32'h2000, 32'h180, 32'h0, 32'h0, 32'h0, 32'h0BADF00D, 5'd6, 3));
        runOp("store1wait", mkOp(0,0,1,0,0,0,0, 32'h2004, 32'h40, 32'h12345678, 32'h0, 32'h0, 32'h0, 5'd1, 1));
        runOp("loadTimeout", mkOp(1,1,0,1,0,0,0, 32'h2008, 32'h184, 32'h0, 32'h0, 32'h0, 32'h55AA55AA, 5'd8, 99));
        runOp("afterTimeout", mkOp(1,0,0,0,0,0,0, 32'h200C, 32'h99, 32'h0, 32'h0, 32'h0, 32'h0, 5'd10, 0));
        runOp("storeTimeout", mkOp(0,0,1,0,0,0,0, 32'h2010, 32'h44, 32'h87654321, 32'h0, 32'h0, 32'h0, 5'd2, 99));

        // Reset in the second WAIT cycle abandons the load
        op = mkOp(1,1,0,1,0,0,0, 32'h3000, 32'h1C0, 32'h0, 32'h0, 32'h0, 32'h13579BDF, 5'd12, 99);
        applyStimulus(op, 1'b0, 32'h0);
        #1;
        checkBit("rstWait c0 stall", oStall, 1'b1);
        stepClock();
        checkBit("rstWait c1 stall", oStall, 1'b1);
        stepClock();
        reset = 1'b1;
        #1;
        checkBit("rstWait memReq", memBus.oMemReq, 1'b0);
        checkBit("rstWait stall", oStall, 1'b0);
        stepClock();
        checkWb("rstWait", 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0);
        reset = 1'b0;
        expReadData = '0; expResult = '0; expPC = '0; expRegDest = '0;
        runOp("postRstLoad0", mkOp(1,1,0,1,0,0,0, 32'h3004, 32'h1C4, 32'h0, 32'h0, 32'h0, 32'h2468ACE0, 5'd13, 0));
        runOp("postRstLoad2", mkOp(1,1,0,1,0,0,0, 32'h3008, 32'h1C8, 32'h0, 32'h0, 32'h0, 32'h0F0F0F0F, 5'd14, 2));

        // Randomized transactions
        for (int n = 0; n < 80; n++) begin
            runOp($sformatf("rnd%0d", n), randomOp());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
